// File: rtl/tile_pkg.sv
// Shared defaults and the pipeline slot type for the tile pixel lookup.
// Pure declarations: no latency, no backpressure.
// Imported by the FIFO-fed pixel pipeline and its bench.
package tile_pkg;

    localparam int DEF_TILE_SIZE = 10;
    localparam int DEF_TILE_W    = 16;
    localparam int DEF_PIX_W     = 24;
    localparam int DEF_ADDR_W    = 30;

    localparam logic [DEF_TILE_W-1:0] BLANK_TILE      = '1;
    localparam logic [DEF_PIX_W-1:0]  DEF_BLANK_COLOR = '0;
    localparam logic [DEF_PIX_W-1:0]  DEF_KEY_COLOR   = 24'hFF00FF;

    typedef struct packed {
        logic valid;
        logic blank;
    } slot_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with occupancy count, used as the pixel output buffer.
// Latency: a write is visible at the head on the following cycle.
// Backpressure: none internally; the writer must never push when count == DEPTH.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/tile_pixel_pipeline.sv
// Tile pixel lookup: request -> registered tile-memory read -> in-order pixel FIFO.
// Latency: READ_LATENCY+2 cycles from accept to out_valid; one pixel per cycle sustained.
// Backpressure: credits (FIFO + in flight) gate in_ready; TILE_PIXEL_KEY_EN adds key transparency.
module tile_pixel_pipeline
    import tile_pkg::*;
#(
    parameter int TILE_SIZE    = DEF_TILE_SIZE,
    parameter int TILE_W       = DEF_TILE_W,
    parameter int OFS_W        = 8,
    parameter int PIX_W        = DEF_PIX_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter logic [PIX_W-1:0] BLANK_COLOR = PIX_W'(DEF_BLANK_COLOR)
`ifdef TILE_PIXEL_KEY_EN
    , parameter logic [PIX_W-1:0] KEY_COLOR = PIX_W'(DEF_KEY_COLOR)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TILE_W-1:0] in_tile,
    input  logic [OFS_W-1:0]  in_ofs_x,
    input  logic [OFS_W-1:0]  in_ofs_y,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_transparent
);

    localparam int FULL_W = TILE_W + OFS_W + 2 * $clog2(TILE_SIZE + 1) + 2;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
`ifdef TILE_PIXEL_KEY_EN
    localparam int FW     = PIX_W + 1;
`else
    localparam int FW     = PIX_W;
`endif
    localparam logic [OFS_W:0] OFS_LIMIT = (OFS_W + 1)'(TILE_SIZE);

    logic              ready_en;
    logic              in_fire;
    logic              pop;
    logic              req_blank;
    logic [FULL_W-1:0] addr_full;
    logic              mem_rd_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    slot_t             slots [READ_LATENCY+1];
    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  credits_used;
    logic [FW-1:0]     wr_data;
    logic [FW-1:0]     head;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign req_blank = (&in_tile)
                    || ({1'b0, in_ofs_x} >= OFS_LIMIT)
                    || ({1'b0, in_ofs_y} >= OFS_LIMIT);

    assign addr_full = FULL_W'(TILE_SIZE * TILE_SIZE) * FULL_W'(in_tile)
                     + FULL_W'(in_ofs_y) * FULL_W'(TILE_SIZE)
                     + FULL_W'(in_ofs_x);

    // Every accepted request holds one credit until its pixel leaves the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            inflight = inflight + SUM_W'(slots[i].valid);
        end
    end

    assign credits_used = SUM_W'(fifo_count) + inflight;
    assign in_ready     = !rst && ready_en && (credits_used < SUM_W'(FIFO_DEPTH));
    assign in_fire      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                slots[i] <= '0;
            end
        end else begin
            ready_en    <= 1'b1;
            mem_rd_en_q <= in_fire && !req_blank;
            if (in_fire) mem_addr_q <= ADDR_W'(addr_full);
            slots[0] <= '{valid: in_fire, blank: in_fire && req_blank};
            for (int i = 1; i <= READ_LATENCY; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;

    // The last slot lines up with the cycle mem_rd_data is valid for its read.
`ifdef TILE_PIXEL_KEY_EN
    logic key_hit;
    assign key_hit = !slots[READ_LATENCY].blank && (mem_rd_data == KEY_COLOR);
    assign wr_data = {key_hit,
                      (slots[READ_LATENCY].blank || key_hit) ? BLANK_COLOR : mem_rd_data};
`else
    assign wr_data = slots[READ_LATENCY].blank ? BLANK_COLOR : mem_rd_data;
`endif

    pixel_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (slots[READ_LATENCY].valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = !rst && !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_pixel = out_valid ? head[PIX_W-1:0] : '0;
`ifdef TILE_PIXEL_KEY_EN
    assign out_transparent = out_valid && head[PIX_W];
`else
    assign out_transparent = 1'b0;
`endif

endmodule

// File: doc/tile_pixel_pipeline.md
Name: tile_pixel_pipeline

Overview:
- Parametrised, pipelined successor to the single-cycle tile pixel lookup.
- Accepts (tile_number, offset_x, offset_y) requests on a valid/ready handshake and computes the linear tile-memory address.
- Issues reads to a fixed-latency tile memory and returns pixel values, in order, through an output FIFO with backpressure.
- Sits between the screen-position/tile-map stage and the video output stage.

Parameters:
- TILE_SIZE, 10, tile edge length in pixels.
- TILE_W, 16, tile_number width.
- OFS_W, 8, offset_x/offset_y width.
- PIX_W, 24, pixel width.
- ADDR_W, 30, tile-memory address width.
- READ_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (1..8).
- FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+2 for full throughput.
- BLANK_COLOR, 0, value emitted for blank or out-of-range requests.
- KEY_COLOR, 24'hFF00FF, transparency key (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_tile  in  TILE_W  tile number; all-ones = blank tile
- in_ofs_x  in  OFS_W  x offset inside tile
- in_ofs_y  in  OFS_W  y offset inside tile
- mem_rd_en  out  1  tile-memory read strobe
- mem_addr  out  ADDR_W  tile-memory address
- mem_rd_data  in  PIX_W  read data, valid READ_LATENCY cycles after mem_rd_en
- out_valid  out  1  pixel available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_pixel  out  PIX_W  pixel value
- out_transparent  out  1  pixel matched the key (optional feature)

Behaviour:
- Reset: synchronous, active-high. All outputs are 0 while rst is high and in the cycle after it deasserts: in_ready=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_pixel=0, out_transparent=0. Reset clears the FIFO, the in-flight pipeline and the credit counter. Reads in flight when reset asserts are discarded; their returning data is ignored.
- Address: mem_addr = TILE_SIZE*TILE_SIZE*in_tile + in_ofs_y*TILE_SIZE + in_ofs_x. Computed at full precision, then truncated modulo 2^ADDR_W. Registered: request accepted in cycle T drives mem_addr/mem_rd_en in cycle T+1.
- Blank/range: a request is marked blank if in_tile is all-ones, or if in_ofs_x >= TILE_SIZE, or if in_ofs_y >= TILE_SIZE. Blank requests keep mem_rd_en=0 but still occupy a pipeline slot, so ordering is preserved, and they yield BLANK_COLOR.
- Pipeline: a slot shift register of depth READ_LATENCY+1 carries the valid bit and the blank flag alongside the read. Data is written to the FIFO in cycle T+1+READ_LATENCY (mem_rd_data, or BLANK_COLOR if blank).
- Output: FIFO head is registered. out_valid=!empty. Minimum latency from in_fire to out_valid is READ_LATENCY+2 cycles.
- Credits: in_ready = (fifo_count + inflight) < FIFO_DEPTH. Credit is counted at accept time, so the FIFO can never overflow and mem_rd_data is never dropped. A simultaneous FIFO pop and accept in the same cycle is allowed and leaves the count unchanged.
- Throughput: one pixel per cycle when out_ready is held high and FIFO_DEPTH >= READ_LATENCY+2.
- Stall: when out_ready=0, the FIFO fills and in_ready falls. out_pixel is held stable while out_valid & !out_ready.

Optional Feature:
- Macro: TILE_PIXEL_KEY_EN.
- Defined: a non-blank pixel whose value equals KEY_COLOR is replaced by BLANK_COLOR on out_pixel, and out_transparent=1 for that entry.
- Undefined: no comparison logic is built, out_transparent is tied 0, and pixels pass unmodified.

Decomposition:
- Package tile_pkg: default TILE_SIZE, PIX_W, ADDR_W, BLANK_TILE (all-ones constant), BLANK_COLOR, KEY_COLOR; a slot typedef {valid, blank}.
- Sub-module pixel_fifo: synchronous FIFO with width and depth parameters, count output and synchronous rst.

Test Plan:
- Reset mid-stream: 3 reads in flight with READ_LATENCY=3, assert rst -> out_valid stays 0 after reset and FIFO count reads 0.
- Single request: tile=2, x=3, y=4, TILE_SIZE=10 -> mem_addr=243 at T+1; out_pixel equals memory[243] at T+READ_LATENCY+2.
- Blank/out-of-range: tile=16'hFFFF, or x=10 -> mem_rd_en stays 0 and out_pixel=0, in order between two normal pixels.
- Backpressure: 20 back-to-back requests, out_ready toggled 1/0 -> no loss or duplication, in_ready drops when credits reach FIFO_DEPTH, and out_pixel is stable during stalls.
- Throughput: READ_LATENCY=1, FIFO_DEPTH=4, out_ready=1 -> 100 requests complete in 103 cycles.
- TILE_PIXEL_KEY_EN: memory word = 24'hFF00FF -> out_pixel=0 and out_transparent=1; with the macro undefined -> out_pixel=24'hFF00FF and out_transparent=0.
